// File: rtl/seg595_scan_driver.sv
// seg595_scan_driver: hex-to-7-segment scan driver serialising {SEG, SEL} frames onto a 74HC595 chain
module seg595_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCLK_DIV = 1,
    parameter int SCAN_DIV = 5000,
    parameter bit SEG_INV  = 1'b0,
    parameter bit SEL_INV  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [4*DIGITS-1:0]   disp_data_i,
    input  logic [DIGITS-1:0]     dp_mask_i,
    input  logic [DIGITS-1:0]     blank_mask_i,
    input  logic                  lzb_en_i,
    input  logic                  load_i,
    input  logic                  en_i,
    output logic                  sh_cp_o,
    output logic                  st_cp_o,
    output logic                  ds_o,
    output logic                  frame_done_o
);
    localparam int SEL_BITS = 8 * ((DIGITS + 7) / 8);
    localparam int W = 8 + SEL_BITS;
    localparam int BW = $clog2(W);
    localparam int BUF = 6 * DIGITS + 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SHIFT = 3'd2, S_LATCH = 3'd3, S_HOLD = 3'd4;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [2:0] state_q, state_d;
    logic [3:0] dig_q, dig_d;
    logic [BUF-1:0] shadow_q, active_q, in_buf, src, view;
    logic pend_q, take, advance, dwell_done, div_done;
    logic [W-1:0] frame_q, frame_d, frame_new;
    logic [BW-1:0] bit_q, bit_d;
    logic half_q, half_d;
    logic [31:0] div_q, div_d, dwell_q, dwell_d;
    logic ds_q, ds_d, sh_cp_q, st_cp_q, fd_q;
    logic [4*DIGITS-1:0] data_v;
    logic [DIGITS-1:0] dp_v, blank_v, dig_mask;
    logic [3:0] nib;
    logic lzb_hit;
    logic [7:0] seg;
    logic [SEL_BITS-1:0] sel;

    // Buffer layout {lzb, blank, dp, data}; digit-0 LOAD takes a same-cycle Load directly
    always_comb begin
        in_buf = {lzb_en_i, blank_mask_i, dp_mask_i, disp_data_i};
        take = state_q == S_LOAD && dig_q == 4'd0 && (pend_q || load_i);
        src = load_i ? in_buf : shadow_q;
        view = take ? src : active_q;
        data_v = view[4*DIGITS-1:0];
        dp_v = view[5*DIGITS-1:4*DIGITS];
        blank_v = view[6*DIGITS-1:5*DIGITS];
        dig_mask = DIGITS'(1) << dig_q;
        nib = 4'(data_v >> {dig_q, 2'b00});
        lzb_hit = view[BUF-1] && dig_q != 4'd0 && (data_v >> {dig_q, 2'b00}) == '0 && (dp_v >> dig_q) == '0;
        seg = ((|(blank_v & dig_mask)) || lzb_hit ? 8'h00 : {|(dp_v & dig_mask), HEX[nib]}) ^ {8{SEG_INV}};
        sel = (SEL_BITS'(1) << dig_q) ^ {SEL_BITS{SEL_INV}};
        frame_new = {seg, sel};
    end

    // Scan sequencer: LOAD -> SHIFT W bits -> LATCH -> HOLD until the digit dwell expires
    always_comb begin
        state_d = state_q;
        dig_d = dig_q;
        frame_d = frame_q;
        bit_d = bit_q;
        half_d = half_q;
        div_d = div_q;
        ds_d = ds_q;
        advance = 1'b0;
        dwell_done = dwell_q >= 32'(SCAN_DIV - 1);
        div_done = div_q == 32'(SCLK_DIV - 1);
        case (state_q)
            S_IDLE: state_d = en_i ? S_LOAD : S_IDLE;
            S_LOAD: begin
                state_d = S_SHIFT;
                frame_d = frame_new;
                ds_d = frame_new[W-1];
                bit_d = '0;
                half_d = 1'b0;
                div_d = '0;
            end
            S_SHIFT: begin
                div_d = div_done ? 32'd0 : div_q + 32'd1;
                if (div_done) begin
                    half_d = !half_q;
                    if (half_q && bit_q == BW'(W - 1)) begin
                        state_d = S_LATCH;
                    end else if (half_q) begin
                        bit_d = bit_q + 1'b1;
                        frame_d = frame_q << 1;
                        ds_d = frame_q[W-2];
                    end
                end
            end
            S_LATCH: begin
                div_d = div_done ? 32'd0 : div_q + 32'd1;
                advance = div_done && dwell_done;
                state_d = div_done && !dwell_done ? S_HOLD : S_LATCH;
            end
            S_HOLD: advance = dwell_done;
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            dig_d = dig_q == 4'(DIGITS - 1) ? 4'd0 : dig_q + 4'd1;
            state_d = en_i ? S_LOAD : S_IDLE;
        end
        dwell_d = state_d == S_LOAD ? 32'd0 : dwell_q + 32'd1;
    end

    // Shadow/active double buffer; a Load during reset is dropped
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q <= '0;
            active_q <= '0;
            pend_q <= 1'b0;
        end else begin
            shadow_q <= load_i ? in_buf : shadow_q;
            active_q <= take ? src : active_q;
            pend_q <= take ? 1'b0 : (load_i || pend_q);
        end
    end

    // Sequencer state and registered 595 pins derived from next state
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            dig_q <= '0;
            frame_q <= '0;
            bit_q <= '0;
            half_q <= 1'b0;
            div_q <= '0;
            dwell_q <= '0;
            ds_q <= 1'b0;
            sh_cp_q <= 1'b0;
            st_cp_q <= 1'b0;
            fd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q <= dig_d;
            frame_q <= frame_d;
            bit_q <= bit_d;
            half_q <= half_d;
            div_q <= div_d;
            dwell_q <= dwell_d;
            ds_q <= ds_d;
            sh_cp_q <= state_d == S_SHIFT && half_d;
            st_cp_q <= state_d == S_LATCH;
            fd_q <= advance && dig_q == 4'(DIGITS - 1);
        end
    end

    assign sh_cp_o = sh_cp_q;
    assign st_cp_o = st_cp_q;
    assign ds_o = ds_q;
    assign frame_done_o = fd_q;
endmodule

// File: tb/tb_seg595_scan_driver.sv
// tb_seg595_scan_driver: 595-chain model plus spec-level frame model checking the scan driver
module tb_seg595_scan_driver;
    localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic clk = 1'b0, reset = 1'b1, lzb_en = 1'b0, load = 1'b0, en = 1'b1;
    logic [31:0] disp = '0;
    logic [7:0] dpm = '0, blm = '0;
    logic sh_cp, st_cp, ds, fd;
    int checks = 0, failures = 0, cyc = 0, rises_since = 0, sh_total = 0, st_total = 0;
    logic sh_prev = 1'b0, st_prev = 1'b0;
    logic [15:0] sr = '0;
    logic [15:0] lat_frame[$];
    int lat_cyc[$], lat_rises[$], fd_cyc[$];

    seg595_scan_driver #(.DIGITS(8), .SCLK_DIV(1), .SCAN_DIV(100), .SEG_INV(1'b0), .SEL_INV(1'b0)) dut (
        .clk_i(clk), .reset_i(reset), .disp_data_i(disp), .dp_mask_i(dpm), .blank_mask_i(blm),
        .lzb_en_i(lzb_en), .load_i(load), .en_i(en), .sh_cp_o(sh_cp), .st_cp_o(st_cp), .ds_o(ds),
        .frame_done_o(fd)
    );

    always #5 clk = ~clk;

    // 595 chain: shift DS on SH_CP rise, capture the chain on ST_CP rise
    always @(negedge clk) begin
        cyc++;
        if (reset) rises_since = 0;
        if (sh_cp && !sh_prev) begin
            sr = {sr[14:0], ds};
            rises_since++;
            sh_total++;
        end
        if (st_cp && !st_prev) begin
            lat_frame.push_back(sr);
            lat_cyc.push_back(cyc);
            lat_rises.push_back(rises_since);
            rises_since = 0;
            st_total++;
        end
        if (fd) fd_cyc.push_back(cyc);
        sh_prev = sh_cp;
        st_prev = st_cp;
    end

    function automatic logic [15:0] exp_frame(input logic [31:0] d, input logic [7:0] dp,
                                              input logic [7:0] bl, input logic lz, input int i);
        logic [31:0] upper;
        logic [7:0] seg;
        upper = d >> (4 * i);
        seg = {dp[i], TBL[upper[3:0]]};
        if (bl[i] || (lz && i > 0 && upper == 0 && (dp >> i) == 0)) seg = 8'h00;
        return {seg, 8'(1 << i)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q;
        lat_frame.delete();
        lat_cyc.delete();
        lat_rises.delete();
        fd_cyc.delete();
    endtask

    task automatic load_buf(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl, input logic lz);
        disp = d;
        dpm = dp;
        blm = bl;
        lzb_en = lz;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic sync_frame;
        tick();
        for (int k = 0; k < 2000 && fd !== 1'b1; k++) tick();
        checks++;
        if (fd !== 1'b1) begin
            failures++;
            $display("FAIL sync_frame: frame_done=%b within budget, expected 1", fd);
        end
        clear_q();
    endtask

    task automatic wait_latches(input int n);
        for (int k = 0; k < 200 * n + 400 && lat_frame.size() < n; k++) tick();
        checks++;
        if (lat_frame.size() < n) begin
            failures++;
            $display("FAIL latch_count: got %0d ST_CP pulses, expected %0d", lat_frame.size(), n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        en = 1'b1;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sh_cp, st_cp, ds, fd} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_outputs: got %b, expected 0000", {sh_cp, st_cp, ds, fd});
            end
            tick();
        end
        reset = 1'b0;
        clear_q();
        wait_latches(1);
        checks++;
        if (lat_frame[0] !== 16'h3F01) begin
            failures++;
            $display("FAIL first_frame: got %h, expected 3f01", lat_frame[0]);
        end
        checks++;
        if (lat_rises[0] !== 16) begin
            failures++;
            $display("FAIL first_rises: got %0d SH_CP rises, expected 16", lat_rises[0]);
        end
    endtask

    task automatic test_scan;
        load_buf(32'h12345678, 8'h00, 8'h00, 1'b0);
        sync_frame();
        wait_latches(8);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (lat_frame[k] !== exp_frame(32'h12345678, 8'h00, 8'h00, 1'b0, k)) begin
                failures++;
                $display("FAIL scan_digit%0d: got %h, expected %h", k, lat_frame[k], exp_frame(32'h12345678, 8'h00, 8'h00, 1'b0, k));
            end
            checks++;
            if (lat_rises[k] !== 16) begin
                failures++;
                $display("FAIL scan_rises%0d: got %0d, expected 16", k, lat_rises[k]);
            end
            if (k > 0) begin
                checks++;
                if (lat_cyc[k] - lat_cyc[k-1] !== 100) begin
                    failures++;
                    $display("FAIL scan_period%0d: got %0d cycles, expected 100", k, lat_cyc[k] - lat_cyc[k-1]);
                end
            end
        end
        checks++;
        if (lat_frame[0] !== 16'h7F01 || lat_frame[7] !== 16'h0680) begin
            failures++;
            $display("FAIL scan_literal: got %h/%h, expected 7f01/0680", lat_frame[0], lat_frame[7]);
        end
        for (int k = 0; k < 2000 && fd_cyc.size() < 2; k++) tick();
        checks++;
        if (fd_cyc.size() < 2 || fd_cyc[1] - fd_cyc[0] !== 800) begin
            failures++;
            $display("FAIL frame_done_period: got %0d pulses spacing %0d, expected spacing 800",
                     fd_cyc.size(), fd_cyc.size() < 2 ? 0 : fd_cyc[1] - fd_cyc[0]);
        end
    endtask

    task automatic test_lzb;
        logic [7:0] dps [2] = '{8'h00, 8'h10};
        for (int p = 0; p < 2; p++) begin
            load_buf(32'h00000120, dps[p], 8'h00, 1'b1);
            sync_frame();
            wait_latches(8);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (lat_frame[k] !== exp_frame(32'h00000120, dps[p], 8'h00, 1'b1, k)) begin
                    failures++;
                    $display("FAIL lzb%0d_digit%0d: got %h, expected %h", p, k, lat_frame[k], exp_frame(32'h00000120, dps[p], 8'h00, 1'b1, k));
                end
            end
            checks++;
            if (p == 0 ? (lat_frame[7] !== 16'h0080 || lat_frame[2] !== 16'h0604)
                       : (lat_frame[4] !== 16'hBF10 || lat_frame[3] !== 16'h3F08)) begin
                failures++;
                $display("FAIL lzb%0d_literal: got %h/%h/%h/%h", p, lat_frame[7], lat_frame[4], lat_frame[3], lat_frame[2]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [7:0] dp, bl;
        logic lz;
        for (int it = 0; it < 4; it++) begin
            d = $urandom() >> (4 * $urandom_range(0, 7));
            dp = 8'($urandom()) & 8'($urandom());
            bl = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
            lz = 1'($urandom_range(0, 1));
            if (it % 2 == 1) begin
                sync_frame();
                load_buf(d, dp, bl, lz);
            end else begin
                load_buf(d, dp, bl, lz);
                sync_frame();
            end
            wait_latches(8);
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (lat_frame[k] !== exp_frame(d, dp, bl, lz, k)) begin
                    failures++;
                    $display("FAIL random%0d_digit%0d: got %h, expected %h", it, k, lat_frame[k], exp_frame(d, dp, bl, lz, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        load_buf(32'h12345678, 8'h00, 8'h00, 1'b0);
        sync_frame();
        wait_latches(3);
        tick(70);
        load_buf(32'h11111111, 8'h00, 8'h00, 1'b0);
        wait_latches(5);
        tick(70);
        load_buf(32'h22222222, 8'h00, 8'h00, 1'b0);
        wait_latches(16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (lat_frame[k] !== (k < 8 ? exp_frame(32'h12345678, 8'h00, 8'h00, 1'b0, k)
                                        : {8'h5B, 8'(1 << (k - 8))})) begin
                failures++;
                $display("FAIL dbuf_latch%0d: got %h", k, lat_frame[k]);
            end
        end
    endtask

    task automatic test_en_pause;
        int s0, t0;
        sync_frame();
        tick(5);
        en = 1'b0;
        tick(100);
        checks++;
        if (lat_frame.size() !== 1 || lat_frame[0] !== 16'h5B01 || lat_rises[0] !== 16) begin
            failures++;
            $display("FAIL pause_finish: got %0d latches frame %h rises %0d, expected 1/5b01/16",
                     lat_frame.size(), lat_frame[0], lat_rises[0]);
        end
        s0 = sh_total;
        t0 = st_total;
        tick(200);
        checks++;
        if (sh_total !== s0 || st_total !== t0 || sh_cp !== 1'b0 || st_cp !== 1'b0) begin
            failures++;
            $display("FAIL pause_idle: got %0d/%0d new edges sh=%b st=%b, expected 0/0 0 0",
                     sh_total - s0, st_total - t0, sh_cp, st_cp);
        end
        en = 1'b1;
        clear_q();
        wait_latches(1);
        checks++;
        if (lat_frame[0] !== 16'h5B02) begin
            failures++;
            $display("FAIL resume_digit: got %h, expected 5b02", lat_frame[0]);
        end
    endtask

    task automatic test_reset_mid;
        sync_frame();
        tick(5);
        reset = 1'b1;
        disp = 32'h88888888;
        load = 1'b1;
        tick();
        checks++;
        if ({sh_cp, st_cp, ds, fd} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b, expected 0000", {sh_cp, st_cp, ds, fd});
        end
        reset = 1'b0;
        load = 1'b0;
        clear_q();
        wait_latches(2);
        checks++;
        if (lat_frame[0] !== 16'h3F01 || lat_frame[1] !== 16'h3F02 || lat_rises[0] !== 16) begin
            failures++;
            $display("FAIL reset_mid_restart: got %h/%h rises %0d, expected 3f01/3f02/16",
                     lat_frame[0], lat_frame[1], lat_rises[0]);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_random();
        test_back_to_back();
        test_en_pause();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg595_scan_driver.md
# seg595_scan_driver

Parametrised multiplexed 7-segment display driver feeding a daisy-chain of 74HC595 shift registers. It decodes a packed hex word to segment patterns, scans DIGITS digits one at a time, and serialises each {SEG, SEL} frame onto SH_CP/ST_CP/DS. It adds per-digit decimal points, blanking, leading-zero suppression and double-buffered display updates. It sits between the measurement/formatting logic and the board's 595 chain, replacing the fixed 8-digit, 16-bit display path.

## Interface
- DIGITS, 8, number of digits scanned (1..16); SEL_BITS = 8*ceil(DIGITS/8), frame width W = 8 + SEL_BITS
- SCLK_DIV, 1, Clk cycles per SH_CP half-period and ST_CP high time (>=1)
- SCAN_DIV, 5000, Clk cycles of dwell per digit, measured from LOAD entry
- SEG_INV, 0, 1 = invert all SEG bits (common-anode)
- SEL_INV, 0, 1 = invert all SEL bits
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Disp_Data  in  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i]
- Dp_Mask  in  DIGITS  1 = decimal point lit on digit i
- Blank_Mask  in  DIGITS  1 = digit i forced dark
- Lzb_En  in  1  leading-zero blanking enable
- Load  in  1  one-cycle strobe capturing the four inputs above into the shadow buffer
- En  in  1  scan enable
- SH_CP  out  1  595 shift clock
- ST_CP  out  1  595 storage (latch) clock
- DS  out  1  595 serial data
- Frame_Done  out  1  one-cycle pulse after the last digit (DIGITS-1) is latched

One clock; reset is synchronous and active-high.

## Operation
- Decode: 0-F to SEG[6:0] = g..a (SEG[0]=a), SEG[7]=dp, 1 = lit before SEG_INV. Standard hex patterns: 0=0x3F, 1=0x06, 2=0x5B, 8=0x7F, A=0x77, F=0x71.
- SEL: one-hot, bit i set for the current digit, zero-extended to SEL_BITS, then SEL_INV applied.
- Frame = {SEG, SEL}, shifted MSB first: SEG[7] first, SEL[0] last.
- Blank: if Blank_Mask[i] is set, SEG = 0x00 (pre-inversion), dp included.
- LZB, when Lzb_En is set: scanning from digit DIGITS-1 downward, digits with nibble 0 and Dp_Mask bit clear are blanked until the first nonzero nibble or set dp. That digit and all lower digits are shown. Digit 0 is never blanked by LZB.
- Double buffer:
  - Load copies the inputs into the shadow buffer and sets a pending flag.
  - The active buffer is copied from shadow only at LOAD of digit 0 when pending is set; pending then clears.
  - Multiple Loads within a frame: the last one wins.
- FSM:
  - IDLE: SH_CP=ST_CP=0. Goes to LOAD when En=1.
  - LOAD (1 cycle): build frame for the current digit; dwell counter := 0.
  - SHIFT: W bits. Per bit, DS is set at the start of the SH_CP-low phase, then SCLK_DIV cycles low and SCLK_DIV cycles high.
  - LATCH: ST_CP=1 for SCLK_DIV cycles; SH_CP=0.
  - HOLD: wait until the dwell counter reaches SCAN_DIV-1. If the frame already exceeds SCAN_DIV, HOLD lasts 0 cycles.
  - After HOLD: the digit index advances, wrapping DIGITS-1 to 0. Frame_Done pulses on the wrap cycle. Next state is LOAD if En=1, else IDLE.
- En=0 mid-digit: the current digit completes through LATCH/HOLD, then the FSM goes to IDLE holding the next index. En=1 resumes at that index.

## Timing
- Frame time = 1 + 2*SCLK_DIV*W + SCLK_DIV cycles. For DIGITS=8, SCLK_DIV=1: 1+32+1 = 34.
- Digit period = max(SCAN_DIV, frame time). Full scan = DIGITS × digit period.
- First SH_CP rise occurs SCLK_DIV cycles after the first SHIFT cycle.
- Reset:
  - Outputs: SH_CP=0, ST_CP=0, DS=0, Frame_Done=0.
  - Internal: state IDLE, digit index 0, shadow/active buffers and pending cleared.
  - The next cycle after Reset asserts mid-operation already shows these values.
  - Load coincident with Reset is ignored.
- Load coincident with the LOAD of digit 0: the new data is used by that frame.

## Test plan
- Reset, En=1, Disp_Data=0, masks 0 -> all outputs 0 during reset. The first frame, decoded by a 595-chain model, is SEG=0x3F, SEL=0x01, with exactly 16 SH_CP rises then 1 ST_CP pulse.
- DIGITS=8, SCLK_DIV=1, SCAN_DIV=100, Load 0x12345678 -> digit 0 SEG 0x7F/SEL 0x01, digit 7 SEG 0x06/SEL 0x80. ST_CP pulses every 100 cycles; Frame_Done every 800 cycles.
- Load 0x00000120 with Lzb_En=1 -> digits 7..3 SEG 0x00, digit 2 0x06, digit 1 0x5B, digit 0 0x3F. Adding Dp_Mask=0x10 -> digit 4 0xBF, digit 3 0x3F, digits 7..5 dark.
- Load 0x11111111 at digit 3, then Load 0x22222222 at digit 5 -> digits 3..7 of the current frame unchanged. The next frame shows 0x5B on all digits.
- En deasserted mid-SHIFT -> the current frame finishes with one ST_CP pulse, then SH_CP/ST_CP stay 0. Reasserting En -> the next digit index is scanned.
- Reset asserted mid-SHIFT for 1 cycle -> next cycle all outputs 0. After release with En=1, scanning restarts at digit 0 with SEG 0x3F.
